mst_rx_cmd_dec: RTL and testbench

- Downstream consumer of the master-FIFO receive path: taps the internal FIFO write strobe (ififowr / ififowrid / ififo_wdat) produced by mst_fifo_fsm.
- Parses framed command packets on one selected channel and turns write-burst packets into register-bus writes.
- Decouples the non-stallable receive stream from the register bus through a small output queue.
- Reports packet completion, checksum and framing errors, and counters.

---
 rtl/mst_rx_cmd_dec_if.sv | 11 +
 rtl/mst_rx_cmd_dec.sv | 243 ++++++++++++++++++++++++
 tb/tb_mst_rx_cmd_dec.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mst_rx_cmd_dec_if.sv
// Register-write bus between the command decoder (master) and the register file (slave).
// Valid/ready handshake: a write transfers on the cycle reg_vld & reg_rdy.
interface mst_rx_cmd_dec_if;
  logic        reg_vld;
  logic        reg_rdy;
  logic [15:0] reg_addr;
  logic [31:0] reg_wdat;

  modport master (output reg_vld, output reg_addr, output reg_wdat, input reg_rdy);
  modport slave  (input reg_vld, input reg_addr, input reg_wdat, output reg_rdy);
endinterface

// File: rtl/mst_rx_cmd_dec.sv
// Command-packet decoder on one master-FIFO receive channel; write bursts become register writes.
// Optional in-packet idle timeout is built only when MST_CMD_TIMEOUT_EN is defined.
module mst_rx_cmd_dec #(
  parameter logic [1:0]  CHN       = 2'd0,
  parameter int          QDEP_LOG2 = 2,
  parameter logic [15:0] TO_CYC    = 16'd1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    ififowr,
  input  logic [1:0]              ififowrid,
  input  logic [35:0]             ififo_wdat,
  mst_rx_cmd_dec_if.master        reg_bus,
  output logic                    pkt_done,
  output logic                    pkt_err,
  output logic [2:0]              err_code,
  output logic                    ovf,
  output logic [15:0]             pkt_cnt,
  output logic [7:0]              err_cnt
);

  localparam int QDEP = 1 << QDEP_LOG2;

  typedef enum logic [1:0] {HUNT, LEN, PAY, CSUM} state_t;

  state_t      state, state_n;
  logic        acc, be_ok;
  logic [31:0] word;
  logic [7:0]  opcode;
  logic [15:0] addr;
  logic [31:0] csum;
  logic [7:0]  remain;

  logic        push, hdr_ld, len_ld, pay_step;
  logic        done_ev, err_ev;
  logic [2:0]  err_code_ev;

  logic [15:0]          q_addr [QDEP];
  logic [31:0]          q_data [QDEP];
  logic [QDEP_LOG2-1:0] wr_ptr, rd_ptr;
  logic [QDEP_LOG2:0]   q_cnt;
  logic                 q_full, q_pop, q_wr;
  logic [15:0]          last_addr;
  logic [31:0]          last_data;

  assign acc   = ififowr && (ififowrid == CHN);
  assign be_ok = (ififo_wdat[35:32] == 4'hF);
  assign word  = ififo_wdat[31:0];

`ifdef MST_CMD_TIMEOUT_EN
  logic [15:0] idle_cnt;
  logic        timeout;

  assign timeout = !acc && (state != HUNT) && (idle_cnt == TO_CYC - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      idle_cnt <= 16'd0;
    else if (clr || acc || state == HUNT || state_n == HUNT)
      idle_cnt <= 16'd0;
    else
      idle_cnt <= idle_cnt + 16'd1;
  end
`else
  logic unused_to_cyc;
  assign unused_to_cyc = ^TO_CYC;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= HUNT;
    else if (clr)
      state <= HUNT;
    else
      state <= state_n;
  end

  // A bad byte-enable aborts from any state and is never taken as a header.
  always_comb begin
    state_n     = state;
    push        = 1'b0;
    hdr_ld      = 1'b0;
    len_ld      = 1'b0;
    pay_step    = 1'b0;
    done_ev     = 1'b0;
    err_ev      = 1'b0;
    err_code_ev = 3'd0;
    if (acc) begin
      if (!be_ok) begin
        err_ev      = 1'b1;
        err_code_ev = 3'd3;
        state_n     = HUNT;
      end else begin
        case (state)
          HUNT: begin
            if (word[31:24] == 8'hA5) begin
              hdr_ld  = 1'b1;
              state_n = LEN;
            end else begin
              err_ev      = 1'b1;
              err_code_ev = 3'd1;
            end
          end
          LEN: begin
            if (word[31:8] != 24'd0 || word[7:0] == 8'd0) begin
              err_ev      = 1'b1;
              err_code_ev = 3'd2;
              state_n     = HUNT;
            end else begin
              len_ld  = 1'b1;
              state_n = PAY;
            end
          end
          PAY: begin
            pay_step = 1'b1;
            push     = (opcode == 8'h01);
            if (remain == 8'd1)
              state_n = CSUM;
          end
          CSUM: begin
            state_n = HUNT;
            if (word != csum) begin
              err_ev      = 1'b1;
              err_code_ev = 3'd4;
            end else if (opcode != 8'h01) begin
              err_ev      = 1'b1;
              err_code_ev = 3'd5;
            end else begin
              done_ev = 1'b1;
            end
          end
          default: state_n = HUNT;
        endcase
      end
    end
`ifdef MST_CMD_TIMEOUT_EN
    else if (timeout) begin
      err_ev      = 1'b1;
      err_code_ev = 3'd6;
      state_n     = HUNT;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode <= 8'd0;
      addr   <= 16'd0;
      csum   <= 32'd0;
      remain <= 8'd0;
    end else if (!clr) begin
      if (hdr_ld) begin
        opcode <= word[23:16];
        addr   <= word[15:0];
        csum   <= word;
      end
      if (len_ld) begin
        remain <= word[7:0];
        csum   <= csum ^ word;
      end
      if (pay_step) begin
        remain <= remain - 8'd1;
        csum   <= csum ^ word;
        if (push)
          addr <= addr + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_done <= 1'b0;
      pkt_err  <= 1'b0;
      err_code <= 3'd0;
      pkt_cnt  <= 16'd0;
      err_cnt  <= 8'd0;
    end else if (clr) begin
      pkt_done <= 1'b0;
      pkt_err  <= 1'b0;
      err_code <= 3'd0;
      pkt_cnt  <= 16'd0;
      err_cnt  <= 8'd0;
    end else begin
      pkt_done <= done_ev;
      pkt_err  <= err_ev;
      if (err_ev) begin
        err_code <= err_code_ev;
        if (err_cnt != 8'hFF)
          err_cnt <= err_cnt + 8'd1;
      end
      if (done_ev)
        pkt_cnt <= pkt_cnt + 16'd1;
    end
  end

  // A push into a full queue is still legal when the head leaves in the same cycle.
  assign q_full = (q_cnt == (QDEP_LOG2+1)'(QDEP));
  assign q_pop  = reg_bus.reg_vld && reg_bus.reg_rdy;
  assign q_wr   = push && (!q_full || q_pop) && !clr;

  always_ff @(posedge clk) begin
    if (q_wr) begin
      q_addr[wr_ptr] <= addr;
      q_data[wr_ptr] <= word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      q_cnt     <= '0;
      ovf       <= 1'b0;
      last_addr <= 16'd0;
      last_data <= 32'd0;
    end else if (clr) begin
      rd_ptr <= wr_ptr;
      q_cnt  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (q_wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (q_pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_addr <= q_addr[rd_ptr];
        last_data <= q_data[rd_ptr];
      end
      if (q_wr && !q_pop)
        q_cnt <= q_cnt + 1'b1;
      else if (!q_wr && q_pop)
        q_cnt <= q_cnt - 1'b1;
      if (push && q_full && !q_pop)
        ovf <= 1'b1;
    end
  end

  // Once drained, the bus keeps presenting the last write that left the queue.
  assign reg_bus.reg_vld  = (q_cnt != '0);
  assign reg_bus.reg_addr = reg_bus.reg_vld ? q_addr[rd_ptr] : last_addr;
  assign reg_bus.reg_wdat = reg_bus.reg_vld ? q_data[rd_ptr] : last_data;

endmodule

// File: tb/tb_mst_rx_cmd_dec.sv
// Testbench for mst_rx_cmd_dec: packet-position model checked every cycle plus literal checkpoints.
// Define MST_CMD_TIMEOUT_EN to also exercise the idle timeout (TO_CYC=8).
module tb_mst_rx_cmd_dec;

  localparam logic [15:0] TB_TO = 16'd8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        ififowr;
  logic [1:0]  ififowrid;
  logic [35:0] ififo_wdat;
  logic        rdy;
  logic        pkt_done, pkt_err, ovf;
  logic [2:0]  err_code;
  logic [15:0] pkt_cnt;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  mst_rx_cmd_dec_if bus ();
  assign bus.reg_rdy = rdy;

  mst_rx_cmd_dec #(.CHN(2'd0), .QDEP_LOG2(2), .TO_CYC(TB_TO)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .ififowr(ififowr), .ififowrid(ififowrid), .ififo_wdat(ififo_wdat),
    .reg_bus(bus),
    .pkt_done(pkt_done), .pkt_err(pkt_err), .err_code(err_code), .ovf(ovf),
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Model: position inside the current packet, words seen so far, expected write queue.
  int          pos;
  int          n_pay;
  int          idle;
  logic [31:0] pw[$];
  logic [47:0] exp_q[$];
  logic [47:0] exp_last;
  logic        exp_done, exp_err, exp_ovf;
  logic [2:0]  exp_code;
  logic [15:0] exp_pkt;
  logic [7:0]  exp_errc;
  logic [47:0] obs[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void flag_err(input logic [2:0] code);
    exp_err  = 1'b1;
    exp_code = code;
    if (exp_errc != 8'hFF) exp_errc = exp_errc + 8'd1;
    pos = 0;
  endfunction

  function automatic logic [31:0] xor_all();
    logic [31:0] r = 32'd0;
    foreach (pw[i]) r ^= pw[i];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos = 0; n_pay = 0; idle = 0; pw.delete(); exp_q.delete();
      exp_last = '0; exp_done = 0; exp_err = 0; exp_ovf = 0;
      exp_code = 0; exp_pkt = 0; exp_errc = 0;
    end else begin
      logic        acc, pop;
      logic [31:0] w;
      exp_done = 0;
      exp_err  = 0;
      acc = ififowr && ififowrid == 2'd0;
      w   = ififo_wdat[31:0];
      pop = exp_q.size() != 0 && rdy;
      if (pop) exp_last = exp_q.pop_front();
      if (clr) begin
        pos = 0; idle = 0; exp_q.delete();
        exp_ovf = 0; exp_code = 0; exp_pkt = 0; exp_errc = 0;
      end else if (acc) begin
        idle = 0;
        if (ififo_wdat[35:32] != 4'hF) flag_err(3'd3);
        else if (pos == 0) begin
          if (w[31:24] == 8'hA5) begin pw = '{w}; pos = 1; end
          else flag_err(3'd1);
        end else if (pos == 1) begin
          if (w[31:8] != 0 || w[7:0] == 0) flag_err(3'd2);
          else begin n_pay = w[7:0]; pw.push_back(w); pos = 2; end
        end else if (pos <= n_pay + 1) begin
          pw.push_back(w);
          if (pw[0][23:16] == 8'h01) begin
            if (exp_q.size() < 4) exp_q.push_back({16'(pw[0][15:0] + 16'(pos - 2)), w});
            else exp_ovf = 1;
          end
          pos++;
        end else begin
          if (w != xor_all()) flag_err(3'd4);
          else if (pw[0][23:16] != 8'h01) flag_err(3'd5);
          else begin exp_done = 1; exp_pkt = exp_pkt + 16'd1; pos = 0; end
        end
      end else if (pos != 0) begin
        idle++;
`ifdef MST_CMD_TIMEOUT_EN
        if (idle == int'(TB_TO)) begin flag_err(3'd6); idle = 0; end
`endif
      end else idle = 0;
    end
  end

  // Every cycle: all outputs against the model; observed bus transfers logged for literal checks.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("reg_vld", bus.reg_vld, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        checkOutput("reg_addr", bus.reg_addr, exp_q[0][47:32]);
        checkOutput("reg_wdat", bus.reg_wdat, exp_q[0][31:0]);
      end else begin
        checkOutput("reg_addr_hold", bus.reg_addr, exp_last[47:32]);
        checkOutput("reg_wdat_hold", bus.reg_wdat, exp_last[31:0]);
      end
      checkOutput("pkt_done", pkt_done, exp_done);
      checkOutput("pkt_err", pkt_err, exp_err);
      checkOutput("err_code", err_code, exp_code);
      checkOutput("ovf", ovf, exp_ovf);
      checkOutput("pkt_cnt", pkt_cnt, exp_pkt);
      checkOutput("err_cnt", err_cnt, exp_errc);
      if (bus.reg_vld && rdy) obs.push_back({bus.reg_addr, bus.reg_wdat});
    end
  end

  task automatic applyStimulus(input logic wr, input logic [1:0] id, input logic [35:0] d);
    ififowr    = wr;
    ififowrid  = id;
    ififo_wdat = d;
    @(posedge clk);
    #1;
    ififowr = 1'b0;
  endtask

  task automatic send(input logic [31:0] w);
    applyStimulus(1'b1, 2'd0, {4'hF, w});
  endtask

  task automatic idle_cyc(input int n);
    repeat (n) applyStimulus(1'b0, 2'd0, 36'd0);
  endtask

  logic [31:0] pl[$];

  task automatic send_packet(input logic [7:0] op, input logic [15:0] a, input logic [31:0] mask);
    logic [31:0] h, l, c;
    h = {8'hA5, op, a};
    l = 32'(pl.size());
    c = h ^ l;
    send(h);
    send(l);
    foreach (pl[i]) begin c ^= pl[i]; send(pl[i]); end
    send(c ^ mask);
  endtask

  task automatic check_obs(input int idx, input logic [47:0] exp);
    if (idx < obs.size()) checkOutput($sformatf("write%0d", idx), obs[idx], exp);
    else checkOutput($sformatf("write%0d_missing", idx), 64'(obs.size()), 64'(idx + 1));
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; rdy = 1'b1;
    ififowr = 1'b0; ififowrid = 2'd0; ififo_wdat = 36'd0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    checkOutput("reset_vld", bus.reg_vld, 1'b0);
    checkOutput("reset_pkt_cnt", pkt_cnt, 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cyc(2);

    // Good write burst with a literal checksum.
    obs.delete();
    send(32'hA5011000); send(32'h00000002); send(32'hDEADBEEF); send(32'h12345678);
    send(32'h6998F895);
    checkOutput("t1_done", pkt_done, 1'b1);
    idle_cyc(3);
    checkOutput("t1_pkt_cnt", pkt_cnt, 16'd1);
    check_obs(0, {16'h1000, 32'hDEADBEEF});
    check_obs(1, {16'h1001, 32'h12345678});

    // Corrupted checksum: writes still issue, verdict is an error.
    obs.delete();
    pl = '{32'hDEADBEEF, 32'h12345678};
    send_packet(8'h01, 16'h1000, 32'h1);
    checkOutput("t2_err", pkt_err, 1'b1);
    idle_cyc(3);
    checkOutput("t2_code", err_code, 3'd4);
    checkOutput("t2_err_cnt", err_cnt, 8'd1);
    checkOutput("t2_pkt_cnt", pkt_cnt, 16'd1);
    check_obs(1, {16'h1001, 32'h12345678});

    // Garbage word, then a packet with other-channel words interleaved.
    obs.delete();
    send(32'h11223344);
    send(32'hA5011000);
    applyStimulus(1'b1, 2'd1, {4'hF, 32'hA5FFFFFF});
    send(32'h00000001);
    applyStimulus(1'b1, 2'd2, {4'h7, 32'h0});
    send(32'hCAFEF00D);
    idle_cyc(1);
    send(32'hA5011000 ^ 32'h00000001 ^ 32'hCAFEF00D);
    idle_cyc(3);
    checkOutput("t3_code", err_code, 3'd1);
    checkOutput("t3_err_cnt", err_cnt, 8'd2);
    checkOutput("t3_pkt_cnt", pkt_cnt, 16'd2);
    check_obs(0, {16'h1000, 32'hCAFEF00D});

    // Stalled bus: 6-word burst overflows a 4-entry queue.
    obs.delete();
    rdy = 1'b0;
    pl = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105};
    send_packet(8'h01, 16'h1000, 32'h0);
    checkOutput("t4_done", pkt_done, 1'b1);
    idle_cyc(1);
    checkOutput("t4_ovf", ovf, 1'b1);
    checkOutput("t4_pkt_cnt", pkt_cnt, 16'd3);
    rdy = 1'b1;
    idle_cyc(6);
    checkOutput("t4_drained", 64'(obs.size()), 64'd4);
    for (int i = 0; i < 4; i++) check_obs(i, {16'(16'h1000 + i), 32'(32'h100 + i)});

    // Bad byte enable mid-payload, zero length, and a non-write opcode.
    send(32'hA5011000); send(32'h00000002); send(32'hDEADBEEF);
    applyStimulus(1'b1, 2'd0, {4'h7, 32'h12345678});
    idle_cyc(2);
    checkOutput("t5_be_code", err_code, 3'd3);
    send(32'hA5011000); send(32'h00000000);
    idle_cyc(2);
    checkOutput("t5_len_code", err_code, 3'd2);
    pl = '{32'h0BADF00D};
    send_packet(8'h02, 16'h2000, 32'h0);
    idle_cyc(2);
    checkOutput("t5_op_code", err_code, 3'd5);
    checkOutput("t5_err_cnt", err_cnt, 8'd5);

    // Reset asserted mid-payload with writes queued.
    rdy = 1'b0;
    send(32'hA5013000); send(32'h00000003); send(32'h55AA55AA);
    rst_n = 1'b0;
    idle_cyc(2);
    checkOutput("t6_vld", bus.reg_vld, 1'b0);
    checkOutput("t6_ovf", ovf, 1'b0);
    checkOutput("t6_err_cnt", err_cnt, 8'd0);
    checkOutput("t6_pkt_cnt", pkt_cnt, 16'd0);
    rst_n = 1'b1;
    rdy = 1'b1;
    idle_cyc(1);
    obs.delete();
    pl = '{32'hDEADBEEF, 32'h12345678};
    send_packet(8'h01, 16'h1000, 32'h0);
    idle_cyc(3);
    checkOutput("t6_after_pkt", pkt_cnt, 16'd1);
    check_obs(0, {16'h1000, 32'hDEADBEEF});

    // Clear wins over a simultaneous accepted word.
    rdy = 1'b0;
    send(32'hA5014000); send(32'h00000002); send(32'h00000011);
    clr = 1'b1;
    send(32'h00000022);
    clr = 1'b0;
    checkOutput("t7_vld", bus.reg_vld, 1'b0);
    checkOutput("t7_pkt_cnt", pkt_cnt, 16'd0);
    rdy = 1'b1;
    pl = '{32'h77};
    send_packet(8'h01, 16'h4000, 32'h0);
    idle_cyc(3);
    checkOutput("t7_after_pkt", pkt_cnt, 16'd1);
    checkOutput("t7_err_cnt", err_cnt, 8'd0);

`ifdef MST_CMD_TIMEOUT_EN
    // Stalled packet times out after TO_CYC idle cycles.
    send(32'hA5011000); send(32'h00000002);
    idle_cyc(int'(TB_TO) + 2);
    checkOutput("t8_code", err_code, 3'd6);
    checkOutput("t8_err_cnt", err_cnt, 8'd1);
    pl = '{32'h1, 32'h2};
    send_packet(8'h01, 16'h5000, 32'h0);
    idle_cyc(3);
    checkOutput("t8_pkt_cnt", pkt_cnt, 16'd2);
`endif

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
